// File: rtl/el2_regfile_snap_ctrl_pkg.sv
// Shared types for the register snapshot controller: FSM encoding, word indices,
// exposed GPR/TLU bundles and the flattening of those bundles into snapshot words.
package el2_pkg;

  localparam int SNAP_NUM_WORDS = 26;
  localparam int SNAP_IDX_W     = 5;

  localparam logic [SNAP_IDX_W-1:0] SNAP_IDX_PC   = 5'd11;
  localparam logic [SNAP_IDX_W-1:0] SNAP_IDX_MRAC = 5'd25;

  localparam logic [1:0] SNAP_ST_IDLE   = 2'd0;
  localparam logic [1:0] SNAP_ST_STREAM = 2'd1;
  localparam logic [1:0] SNAP_ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    SNAP_IDLE   = SNAP_ST_IDLE,
    SNAP_STREAM = SNAP_ST_STREAM,
    SNAP_DONE   = SNAP_ST_DONE
  } el2_snap_state_t;

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] sp;
    logic [31:0] fp;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic [31:0] a4;
    logic [31:0] a5;
    logic [31:0] a6;
    logic [31:0] a7;
  } el2_gpr_pkt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mip;
    logic [31:0] mcyclel;
    logic [31:0] mcycleh;
    logic [31:0] minstretl;
    logic [31:0] minstreth;
    logic [31:0] mrac;
  } el2_tlu_pkt_t;

  typedef logic [SNAP_NUM_WORDS-1:0][31:0] el2_snap_words_t;

  // Word order seen by the consumer: GPRs first, then TLU state starting at pc.
  function automatic el2_snap_words_t snap_pack(input el2_gpr_pkt_t g, input el2_tlu_pkt_t t);
    el2_snap_words_t w;
    w                = '0;
    w[0]             = g.ra;
    w[1]             = g.sp;
    w[2]             = g.fp;
    w[3]             = g.a0;
    w[4]             = g.a1;
    w[5]             = g.a2;
    w[6]             = g.a3;
    w[7]             = g.a4;
    w[8]             = g.a5;
    w[9]             = g.a6;
    w[10]            = g.a7;
    w[SNAP_IDX_PC]   = t.pc;
    w[12]            = t.npc;
    w[13]            = t.mstatus;
    w[14]            = t.mie;
    w[15]            = t.mtvec;
    w[16]            = t.mscratch;
    w[17]            = t.mepc;
    w[18]            = t.mcause;
    w[19]            = t.mtval;
    w[20]            = t.mip;
    w[21]            = t.mcyclel;
    w[22]            = t.mcycleh;
    w[23]            = t.minstretl;
    w[24]            = t.minstreth;
    w[SNAP_IDX_MRAC] = t.mrac;
    return w;
  endfunction

endpackage

// File: rtl/el2_regfile_snap_ctrl_if.sv
// Register-exposure bundle from the core: the source drives live GPR/TLU state,
// the sink only observes it.
interface el2_regfile_if;

  el2_pkg::el2_gpr_pkt_t gpr;
  el2_pkg::el2_tlu_pkt_t tlu;

  modport veer_rf_source (output gpr, output tlu);
  modport veer_rf_sink   (input  gpr, input  tlu);

endinterface

// File: rtl/el2_regfile_snap_ctrl_next_idx.sv
// Finds the lowest set mask bit at or above i_from; used to skip unselected words
// without spending cycles (only instantiated when RV_RF_SNAP_MASK_EN is defined).
module el2_snap_next_idx
  import el2_pkg::*;
(
  input  logic [SNAP_NUM_WORDS-1:0] i_mask,
  input  logic [SNAP_IDX_W-1:0]     i_from,
  output logic                      o_found,
  output logic [SNAP_IDX_W-1:0]     o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < SNAP_NUM_WORDS; i++) begin
      if (!o_found && i_mask[i] && (5'(i) >= i_from)) begin
        o_found = 1'b1;
        o_idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/el2_regfile_snap_ctrl.sv
// Snapshot controller: captures all exposed registers in one cycle, then streams
// them one word per valid/ready beat. Optional word selection under RV_RF_SNAP_MASK_EN.
module el2_regfile_snap_ctrl
  import el2_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  el2_regfile_if.veer_rf_sink      rf,
  input  logic                     snap_req,
  input  logic                     snap_abort,
`ifdef RV_RF_SNAP_MASK_EN
  input  logic [SNAP_NUM_WORDS-1:0] snap_mask,
`endif
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [SNAP_IDX_W-1:0]    out_idx,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     snap_busy,
  output logic                     snap_done,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic [1:0]               dbg_state
);

  // Output port: out_valid/out_idx/out_data/out_last form one beat; a beat
  // transfers when out_valid && out_ready on a rising clk. While out_valid is high
  // and out_ready low, idx/data/last are held and out_valid never drops except
  // through snap_abort.

  el2_snap_state_t           r_state;
  el2_snap_words_t           r_shadow;
  logic [SNAP_IDX_W-1:0]     r_idx;
  logic [DROP_CNT_W-1:0]     r_drop;

  logic                      w_hs;
  logic                      w_last;
  logic [SNAP_IDX_W-1:0]     w_next_idx;
  logic                      w_busy_req;

`ifdef RV_RF_SNAP_MASK_EN
  logic [SNAP_NUM_WORDS-1:0] r_mask;
  logic                      w_more;
  logic                      w_first_found;
  logic [SNAP_IDX_W-1:0]     w_first_idx;

  el2_snap_next_idx u_next (
    .i_mask  (r_mask),
    .i_from  (r_idx + 5'd1),
    .o_found (w_more),
    .o_idx   (w_next_idx)
  );

  el2_snap_next_idx u_first (
    .i_mask  (snap_mask),
    .i_from  (5'd0),
    .o_found (w_first_found),
    .o_idx   (w_first_idx)
  );

  assign w_last = !w_more;
`else
  assign w_last     = (r_idx == SNAP_IDX_MRAC);
  assign w_next_idx = r_idx + 5'd1;
`endif

  assign w_hs       = (r_state == SNAP_STREAM) && out_ready;
  assign w_busy_req = snap_req && (r_state != SNAP_IDLE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= SNAP_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
`ifdef RV_RF_SNAP_MASK_EN
      r_mask   <= '0;
`endif
    end else begin
      case (r_state)
        SNAP_IDLE: begin
          // A same-cycle abort is irrelevant here: the request always wins in IDLE.
          if (snap_req) begin
            r_shadow <= snap_pack(rf.gpr, rf.tlu);
`ifdef RV_RF_SNAP_MASK_EN
            r_mask   <= snap_mask;
            if (w_first_found) begin
              r_state <= SNAP_STREAM;
              r_idx   <= w_first_idx;
            end else begin
              r_state <= SNAP_DONE;
              r_idx   <= '0;
            end
`else
            r_state  <= SNAP_STREAM;
            r_idx    <= '0;
`endif
          end
        end
        SNAP_STREAM: begin
          if (snap_abort) begin
            r_state <= SNAP_IDLE;
            r_idx   <= '0;
          end else if (w_hs) begin
            if (w_last) begin
              r_state <= SNAP_DONE;
              r_idx   <= '0;
            end else begin
              r_idx   <= w_next_idx;
            end
          end
        end
        SNAP_DONE: begin
          r_state <= SNAP_IDLE;
        end
        default: begin
          r_state <= SNAP_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_drop <= '0;
    end else if (w_busy_req && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_CNT_W'(1);
    end
  end

  assign out_valid = (r_state == SNAP_STREAM);
  assign out_idx   = r_idx;
  assign out_data  = r_shadow[r_idx];
  assign out_last  = out_valid && w_last;
  assign snap_busy = (r_state != SNAP_IDLE);
  assign snap_done = (r_state == SNAP_DONE);
  assign drop_cnt  = r_drop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_el2_regfile_snap_ctrl.sv
// Directed bench for the snapshot controller: table of expected beats plus
// hand-written sequences for stalls, drops, abort and masking.
module tb_el2_regfile_snap_ctrl;
  import el2_pkg::*;

  localparam int DW = 8;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_l;
  logic           snap_req;
  logic           snap_abort;
  logic [25:0]    snap_mask;
  logic           out_ready;
  logic           out_valid;
  logic [4:0]     out_idx;
  logic [31:0]    out_data;
  logic           out_last;
  logic           snap_busy;
  logic           snap_done;
  logic [DW-1:0]  drop_cnt;
  logic [1:0]     dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] word_val [26];
  vec_t        vec [26];
  logic [37:0] exp_q [$];

  el2_regfile_if rf_if ();

  el2_regfile_snap_ctrl #(.DROP_CNT_W(DW)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .rf         (rf_if),
    .snap_req   (snap_req),
    .snap_abort (snap_abort),
`ifdef RV_RF_SNAP_MASK_EN
    .snap_mask  (snap_mask),
`endif
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last),
    .snap_busy  (snap_busy),
    .snap_done  (snap_done),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_rf();
    rf_if.gpr.ra        = word_val[0];
    rf_if.gpr.sp        = word_val[1];
    rf_if.gpr.fp        = word_val[2];
    rf_if.gpr.a0        = word_val[3];
    rf_if.gpr.a1        = word_val[4];
    rf_if.gpr.a2        = word_val[5];
    rf_if.gpr.a3        = word_val[6];
    rf_if.gpr.a4        = word_val[7];
    rf_if.gpr.a5        = word_val[8];
    rf_if.gpr.a6        = word_val[9];
    rf_if.gpr.a7        = word_val[10];
    rf_if.tlu.pc        = word_val[11];
    rf_if.tlu.npc       = word_val[12];
    rf_if.tlu.mstatus   = word_val[13];
    rf_if.tlu.mie       = word_val[14];
    rf_if.tlu.mtvec     = word_val[15];
    rf_if.tlu.mscratch  = word_val[16];
    rf_if.tlu.mepc      = word_val[17];
    rf_if.tlu.mcause    = word_val[18];
    rf_if.tlu.mtval     = word_val[19];
    rf_if.tlu.mip       = word_val[20];
    rf_if.tlu.mcyclel   = word_val[21];
    rf_if.tlu.mcycleh   = word_val[22];
    rf_if.tlu.minstretl = word_val[23];
    rf_if.tlu.minstreth = word_val[24];
    rf_if.tlu.mrac      = word_val[25];
  endtask

  task automatic load_all();
    exp_q.delete();
    for (int k = 0; k < 26; k++) exp_q.push_back({vec[k].idx, vec[k].last, vec[k].data});
  endtask

  // Called at a negedge; returns at the negedge one cycle after the request edge.
  task automatic start_req(input bit with_abort, input logic [25:0] mask);
    snap_req   = 1'b1;
    snap_abort = with_abort;
    snap_mask  = mask;
    out_ready  = 1'b0;
    @(negedge clk);
    snap_req   = 1'b0;
    snap_abort = 1'b0;
  endtask

  // Drives out_ready per mode and scores beats against exp_q until snap_done.
  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: 300 stalled cycles with requests.
  task automatic collect(input int mode, input bit req_on_last, input int budget, output int done_cyc);
    logic [37:0] e;
    bit rdy;
    done_cyc = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      snap_req = 1'b0;
      if (snap_done) begin
        check("done_valid_low", out_valid, 0);
        done_cyc = cyc;
        break;
      end
      case (mode)
        1:       rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
        2:       rdy = (cyc > 300);
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      if (mode == 2 && cyc <= 300) snap_req = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q[0];
          check("beat_idx", out_idx, e[37:33]);
          check("beat_data", out_data, e[31:0]);
          check("beat_last", out_last, e[32]);
          if (rdy) begin
            void'(exp_q.pop_front());
            if (req_on_last && e[32]) snap_req = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    snap_req  = 1'b0;
    if (done_cyc == 0) check("stream_timeout", 0, 1);
    check("all_words_delivered", exp_q.size(), 0);
  endtask

  initial begin
    int dc;
    int done_seen;

    word_val = '{32'h1000_0004, 32'h2000_0010, 32'h2000_0020, 32'h0000_00A0,
                 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, 32'h0000_00A4,
                 32'h0000_00A5, 32'h0000_00A6, 32'h0000_00A7, 32'h0000_0100,
                 32'h0000_0104, 32'h0000_1800, 32'h0000_0888, 32'h8000_0000,
                 32'hDEAD_BEEF, 32'h0000_0200, 32'h8000_0007, 32'h0000_0BAD,
                 32'h0000_0080, 32'h1234_5678, 32'h0000_0001, 32'h8765_4321,
                 32'h0000_0002, 32'hAAAA_5555};
    for (int k = 0; k < 26; k++) vec[k] = '{idx: 5'(k), data: word_val[k], last: (k == 25)};

    rst_l = 1'b0; snap_req = 1'b0; snap_abort = 1'b0; snap_mask = '1; out_ready = 1'b0;
    set_rf();
    repeat (2) @(negedge clk);

    // reset state
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", snap_busy, 0);
    check("rst_done", snap_done, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_state", dbg_state, SNAP_ST_IDLE);
    rst_l = 1'b1;
    @(negedge clk);

    // full stream, always ready: beats on cycles 1..26, done on 27
    load_all();
    start_req(1'b0, '1);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_idx", out_idx, 0);
    check("t1_first_data", out_data, 32'h1000_0004);
    check("t1_busy", snap_busy, 1);
    check("t1_state", dbg_state, SNAP_ST_STREAM);
    collect(0, 1'b0, 40, dc);
    check("t1_done_cycle", dc, 27);
    check("t1_done_state", dbg_state, SNAP_ST_DONE);
    check("t1_drop", drop_cnt, 0);
    snap_req = 1'b1;          // request during DONE is rejected
    @(negedge clk);
    snap_req = 1'b0;
    check("t1_drop_in_done", drop_cnt, 1);
    check("t1_idle_after_done", snap_busy, 0);
    check("t1_done_one_cycle", snap_done, 0);
    @(negedge clk);
    check("t1_no_restart", out_valid, 0);

    // stalled stream
    load_all();
    start_req(1'b0, '1);
    collect(1, 1'b0, 200, dc);
    @(negedge clk);

    // frozen shadow: pc changes after capture; request on last handshake is dropped
    load_all();
    start_req(1'b0, '1);
    rf_if.tlu.pc = 32'h200;
    collect(0, 1'b1, 40, dc);
    check("t3_drop_on_last", drop_cnt, 2);
    rf_if.tlu.pc = word_val[11];
    @(negedge clk);
    check("t3_idle", snap_busy, 0);

    // drop counter saturation while stalled
    load_all();
    start_req(1'b0, '1);
    collect(2, 1'b0, 400, dc);
    check("t4_drop_sat", drop_cnt, 8'hFF);
    @(negedge clk);

    // abort at idx 7 with same-cycle handshake
    load_all();
    start_req(1'b0, '1);
    out_ready = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      check("t5_walk_idx", out_idx, 5'(i));
      if (i == 7) snap_abort = 1'b1;
      @(negedge clk);
    end
    snap_abort = 1'b0;
    out_ready  = 1'b0;
    check("t5_abort_valid", out_valid, 0);
    check("t5_abort_busy", snap_busy, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (snap_done) done_seen++;
      @(negedge clk);
    end
    check("t5_no_done", done_seen, 0);
    snap_abort = 1'b1;        // abort in IDLE does nothing
    @(negedge clk);
    snap_abort = 1'b0;
    check("t5_idle_abort", snap_busy, 0);
    load_all();
    start_req(1'b1, '1);      // request + abort together in IDLE: accepted
    check("t5_restart_valid", out_valid, 1);
    check("t5_restart_idx", out_idx, 0);
    collect(0, 1'b0, 40, dc);
    check("t5_restart_done_cycle", dc, 27);
    @(negedge clk);

`ifdef RV_RF_SNAP_MASK_EN
    exp_q.delete();
    exp_q.push_back({5'd0,  1'b0, word_val[0]});
    exp_q.push_back({5'd11, 1'b0, word_val[11]});
    exp_q.push_back({5'd25, 1'b1, word_val[25]});
    start_req(1'b0, 26'h2000801);
    collect(0, 1'b0, 40, dc);
    check("t6_mask_done_cycle", dc, 4);
    @(negedge clk);
    start_req(1'b0, 26'h0);
    check("t6_zero_done", snap_done, 1);
    check("t6_zero_valid", out_valid, 0);
    @(negedge clk);
    check("t6_zero_idle", snap_busy, 0);
    check("t6_zero_done_once", snap_done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
